// File: rtl/npu_queue_pkg.sv
// Shared defaults and pointer-width helper for the CPU<->NPU queue block.
package npu_queue_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_CFG_DEPTH  = 8;
    localparam int unsigned DEF_IN_DEPTH   = 8;
    localparam int unsigned DEF_OUT_DEPTH  = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned DEF_PTR_W = ptr_width(DEF_CFG_DEPTH);

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; flags come from the registered count only.
module npu_sync_fifo
    import npu_queue_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_CFG_DEPTH,
    localparam int unsigned PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop_ok  ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d  = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset; reads of an empty FIFO are masked to zero instead.
    always_ff @(posedge clk_i) begin
        if (push_ok && rst_ni && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/npu_queue_interface.sv
// CPU<->NPU queue block: config/input FIFOs towards the NPU, output FIFO back to the CPU.
// Optional sticky error flag oNpuQueueErr enabled by defining NPU_QUEUE_ERR_EN.
module npu_queue_interface
    import npu_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CFG_DEPTH  = DEF_CFG_DEPTH,
    parameter int unsigned IN_DEPTH   = DEF_IN_DEPTH,
    parameter int unsigned OUT_DEPTH  = DEF_OUT_DEPTH
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iStall,
    input  logic                  iFlush,
    input  logic                  iExNpuCfgOp,
    input  logic                  iExNpuEnqOp,
    input  logic                  iExNpuDeqOp,
    input  logic [DATA_WIDTH-1:0] iExData,
    output logic [DATA_WIDTH-1:0] oDeqData,
    output logic                  oNpuConfigFull,
    output logic                  oNpuInputFull,
    output logic                  oNpuOutputEmpty,
    output logic                  oNpuCfgValid,
    output logic [DATA_WIDTH-1:0] oNpuCfgData,
    input  logic                  iNpuCfgReady,
    output logic                  oNpuInValid,
    output logic [DATA_WIDTH-1:0] oNpuInData,
    input  logic                  iNpuInReady,
    input  logic                  iNpuOutValid,
    input  logic [DATA_WIDTH-1:0] iNpuOutData,
    output logic                  oNpuOutReady
`ifdef NPU_QUEUE_ERR_EN
    ,
    output logic                  oNpuQueueErr
`endif
);

    logic cfg_push, cfg_pop, cfg_empty;
    logic in_push, in_pop, in_empty;
    logic out_push, out_pop, out_full;

    assign cfg_push = iExNpuCfgOp & ~iStall & ~oNpuConfigFull & ~iFlush;
    assign in_push  = iExNpuEnqOp & ~iStall & ~oNpuInputFull & ~iFlush;
    assign out_pop  = iExNpuDeqOp & ~iStall & ~oNpuOutputEmpty & ~iFlush;
    assign cfg_pop  = oNpuCfgValid & iNpuCfgReady & ~iFlush;
    assign in_pop   = oNpuInValid & iNpuInReady & ~iFlush;
    assign out_push = iNpuOutValid & oNpuOutReady & ~iFlush;

    assign oNpuCfgValid = ~cfg_empty;
    assign oNpuInValid  = ~in_empty;
    assign oNpuOutReady = ~out_full;

    npu_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CFG_DEPTH)
    ) u_cfg_fifo (
        .clk_i   (iClk),
        .rst_ni  (iReset_n),
        .flush_i (iFlush),
        .push_i  (cfg_push),
        .wdata_i (iExData),
        .pop_i   (cfg_pop),
        .rdata_o (oNpuCfgData),
        .full_o  (oNpuConfigFull),
        .empty_o (cfg_empty)
    );

    npu_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_DEPTH)
    ) u_in_fifo (
        .clk_i   (iClk),
        .rst_ni  (iReset_n),
        .flush_i (iFlush),
        .push_i  (in_push),
        .wdata_i (iExData),
        .pop_i   (in_pop),
        .rdata_o (oNpuInData),
        .full_o  (oNpuInputFull),
        .empty_o (in_empty)
    );

    npu_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i   (iClk),
        .rst_ni  (iReset_n),
        .flush_i (iFlush),
        .push_i  (out_push),
        .wdata_i (iNpuOutData),
        .pop_i   (out_pop),
        .rdata_o (oDeqData),
        .full_o  (out_full),
        .empty_o (oNpuOutputEmpty)
    );

`ifdef NPU_QUEUE_ERR_EN
    logic err_q, err_d;

    // Stalled ops are retried later, so only unstalled rejections are errors.
    always_comb begin
        err_d = err_q | (~iStall & ((iExNpuCfgOp & oNpuConfigFull) |
                                    (iExNpuEnqOp & oNpuInputFull)  |
                                    (iExNpuDeqOp & oNpuOutputEmpty)));
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n || iFlush) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oNpuQueueErr = err_q;
`endif

endmodule

// File: tb/tb_npu_queue_interface.sv
// Self-checking bench for npu_queue_interface using a queue-based reference model.
module tb_npu_queue_interface;

    localparam int unsigned DW = 32;
    localparam int unsigned D  = 8;

    logic          iClk = 1'b0;
    logic          iReset_n, iStall, iFlush;
    logic          iExNpuCfgOp, iExNpuEnqOp, iExNpuDeqOp;
    logic [DW-1:0] iExData, oDeqData, oNpuCfgData, oNpuInData, iNpuOutData;
    logic          oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty;
    logic          oNpuCfgValid, iNpuCfgReady, oNpuInValid, iNpuInReady;
    logic          iNpuOutValid, oNpuOutReady;
`ifdef NPU_QUEUE_ERR_EN
    logic          oNpuQueueErr;
`endif

    always #5 iClk = ~iClk;

    npu_queue_interface #(
        .DATA_WIDTH (DW),
        .CFG_DEPTH  (D),
        .IN_DEPTH   (D),
        .OUT_DEPTH  (D)
    ) dut (
        .iClk            (iClk),
        .iReset_n        (iReset_n),
        .iStall          (iStall),
        .iFlush          (iFlush),
        .iExNpuCfgOp     (iExNpuCfgOp),
        .iExNpuEnqOp     (iExNpuEnqOp),
        .iExNpuDeqOp     (iExNpuDeqOp),
        .iExData         (iExData),
        .oDeqData        (oDeqData),
        .oNpuConfigFull  (oNpuConfigFull),
        .oNpuInputFull   (oNpuInputFull),
        .oNpuOutputEmpty (oNpuOutputEmpty),
        .oNpuCfgValid    (oNpuCfgValid),
        .oNpuCfgData     (oNpuCfgData),
        .iNpuCfgReady    (iNpuCfgReady),
        .oNpuInValid     (oNpuInValid),
        .oNpuInData      (oNpuInData),
        .iNpuInReady     (iNpuInReady),
        .iNpuOutValid    (iNpuOutValid),
        .iNpuOutData     (iNpuOutData),
        .oNpuOutReady    (oNpuOutReady)
`ifdef NPU_QUEUE_ERR_EN
        ,
        .oNpuQueueErr    (oNpuQueueErr)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] cfg_m[$];
    logic [DW-1:0] in_m[$];
    logic [DW-1:0] out_m[$];
    bit            err_m;

    // {cfgFull, inFull, outEmpty, cfgValid, inValid, outReady}
    logic [5:0] act_flags;
    assign act_flags = {oNpuConfigFull, oNpuInputFull, oNpuOutputEmpty,
                        oNpuCfgValid, oNpuInValid, oNpuOutReady};

    function automatic logic [5:0] exp_flags();
        return {cfg_m.size() == D, in_m.size() == D, out_m.size() == 0,
                cfg_m.size() != 0, in_m.size() != 0, out_m.size() != D};
    endfunction

    task automatic model_edge();
        bit cf, inf, oe, ofl;
        cf  = (cfg_m.size() == D);
        inf = (in_m.size() == D);
        oe  = (out_m.size() == 0);
        ofl = (out_m.size() == D);
        if (!iReset_n || iFlush) begin
            cfg_m.delete();
            in_m.delete();
            out_m.delete();
            err_m = 1'b0;
        end else begin
            if (cfg_m.size() != 0 && iNpuCfgReady) void'(cfg_m.pop_front());
            if (iExNpuCfgOp && !iStall && !cf) cfg_m.push_back(iExData);
            if (in_m.size() != 0 && iNpuInReady) void'(in_m.pop_front());
            if (iExNpuEnqOp && !iStall && !inf) in_m.push_back(iExData);
            if (iExNpuDeqOp && !iStall && !oe) void'(out_m.pop_front());
            if (iNpuOutValid && !ofl) out_m.push_back(iNpuOutData);
            if (!iStall && ((iExNpuCfgOp && cf) || (iExNpuEnqOp && inf) || (iExNpuDeqOp && oe)))
                err_m = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iReset_n     = 1'b1;
        iStall       = 1'b0;
        iFlush       = 1'b0;
        iExNpuCfgOp  = 1'b0;
        iExNpuEnqOp  = 1'b0;
        iExNpuDeqOp  = 1'b0;
        iExData      = '0;
        iNpuCfgReady = 1'b0;
        iNpuInReady  = 1'b0;
        iNpuOutValid = 1'b0;
        iNpuOutData  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        iReset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (act_flags !== 6'b001001) begin
            $display("FAIL reset_flags got %b exp %b", act_flags, 6'b001001);
            errors++;
        end
        checks++;
        if (oDeqData !== '0) begin
            $display("FAIL reset_deqdata got %h exp 0", oDeqData);
            errors++;
        end
        iExNpuCfgOp  = 1'b1;
        iExNpuEnqOp  = 1'b1;
        iNpuOutValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iExData     = $urandom;
            iNpuOutData = $urandom;
            tick();
        end
        checks++;
        if (act_flags !== 6'b001001) begin
            $display("FAIL reset_hold_flags got %b exp %b", act_flags, 6'b001001);
            errors++;
        end
        idle_inputs();
        tick();
        checks++;
        if (act_flags !== 6'b001001) begin
            $display("FAIL reset_release_flags got %b exp %b", act_flags, 6'b001001);
            errors++;
        end
    endtask

    task automatic test_input_fill();
        idle_inputs();
        iExNpuEnqOp = 1'b1;
        for (int unsigned i = 1; i <= D; i++) begin
            iExData = i;
            tick();
            if (i == D - 1) begin
                checks++;
                if (oNpuInputFull !== 1'b0) begin
                    $display("FAIL in_full_early got %b exp 0", oNpuInputFull);
                    errors++;
                end
            end
        end
        checks++;
        if (oNpuInputFull !== 1'b1) begin
            $display("FAIL in_full got %b exp 1", oNpuInputFull);
            errors++;
        end
        iExData = 32'h9;
        tick();
        checks++;
        if (oNpuInputFull !== 1'b1 || oNpuInData !== 32'h1) begin
            $display("FAIL in_overflow got full=%b head=%h exp full=1 head=1", oNpuInputFull, oNpuInData);
            errors++;
        end
        iExNpuEnqOp = 1'b0;
        iNpuInReady = 1'b1;
        for (int unsigned i = 1; i <= D; i++) begin
            checks++;
            if (oNpuInValid !== 1'b1 || oNpuInData !== DW'(i)) begin
                $display("FAIL in_drain got v=%b d=%h exp v=1 d=%h", oNpuInValid, oNpuInData, i);
                errors++;
            end
            tick();
        end
        checks++;
        if (oNpuInValid !== 1'b0) begin
            $display("FAIL in_drained got %b exp 0", oNpuInValid);
            errors++;
        end
        idle_inputs();
    endtask

    task automatic test_output_deq();
        idle_inputs();
        iNpuOutValid = 1'b1;
        iNpuOutData  = 32'hA5;
        tick();
        iNpuOutData  = 32'h5A;
        tick();
        iNpuOutValid = 1'b0;
        iExNpuDeqOp  = 1'b1;
        iStall       = 1'b1;
        tick();
        checks++;
        if (oDeqData !== 32'hA5 || oNpuOutputEmpty !== 1'b0) begin
            $display("FAIL deq_stall got d=%h e=%b exp d=a5 e=0", oDeqData, oNpuOutputEmpty);
            errors++;
        end
        iStall = 1'b0;
        #1;
        checks++;
        if (oDeqData !== 32'hA5) begin
            $display("FAIL deq_first got %h exp a5", oDeqData);
            errors++;
        end
        tick();
        checks++;
        if (oDeqData !== 32'h5A) begin
            $display("FAIL deq_second got %h exp 5a", oDeqData);
            errors++;
        end
        tick();
        checks++;
        if (oNpuOutputEmpty !== 1'b1) begin
            $display("FAIL deq_empty got %b exp 1", oNpuOutputEmpty);
            errors++;
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        iExNpuCfgOp = 1'b1;
        for (int unsigned i = 1; i <= D; i++) begin
            iExData = 32'h10 + i;
            tick();
        end
        iExData      = 32'h99;
        iNpuCfgReady = 1'b1;
        tick();
        iExNpuCfgOp = 1'b0;
        checks++;
        if (oNpuConfigFull !== 1'b0) begin
            $display("FAIL cfg_full_pop got %b exp 0", oNpuConfigFull);
            errors++;
        end
        for (int unsigned i = 2; i <= D; i++) begin
            checks++;
            if (oNpuCfgValid !== 1'b1 || oNpuCfgData !== 32'h10 + i) begin
                $display("FAIL cfg_drain got v=%b d=%h exp v=1 d=%h", oNpuCfgValid, oNpuCfgData, 32'h10 + i);
                errors++;
            end
            tick();
        end
        checks++;
        if (oNpuCfgValid !== 1'b0) begin
            $display("FAIL cfg_drained got %b exp 0", oNpuCfgValid);
            errors++;
        end
        idle_inputs();
        iNpuOutValid = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            iNpuOutData = 32'h20 + i;
            tick();
        end
        iNpuOutData = 32'h24;
        iExNpuDeqOp = 1'b1;
        checks++;
        if (oDeqData !== 32'h20) begin
            $display("FAIL out_pushpop_head got %h exp 20", oDeqData);
            errors++;
        end
        tick();
        iNpuOutValid = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            checks++;
            if (oDeqData !== 32'h20 + i || oNpuOutputEmpty !== 1'b0) begin
                $display("FAIL out_count4 got d=%h e=%b exp d=%h e=0", oDeqData, oNpuOutputEmpty, 32'h20 + i);
                errors++;
            end
            tick();
        end
        checks++;
        if (oNpuOutputEmpty !== 1'b1) begin
            $display("FAIL out_count4_empty got %b exp 1", oNpuOutputEmpty);
            errors++;
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        iExNpuCfgOp  = 1'b1;
        iExNpuEnqOp  = 1'b1;
        iNpuOutValid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            iExData     = 32'h30 + i;
            iNpuOutData = 32'h40 + i;
            tick();
        end
        checks++;
        if (act_flags !== 6'b000111) begin
            $display("FAIL flush_pre got %b exp %b", act_flags, 6'b000111);
            errors++;
        end
        iExNpuCfgOp  = 1'b0;
        iNpuOutValid = 1'b0;
        iFlush       = 1'b1;
        iExData      = 32'h77;
        tick();
        checks++;
        if (act_flags !== 6'b001001) begin
            $display("FAIL flush_post got %b exp %b", act_flags, 6'b001001);
            errors++;
        end
        iFlush      = 1'b0;
        iExNpuEnqOp = 1'b0;
        tick();
        checks++;
        if (act_flags !== 6'b001001) begin
            $display("FAIL flush_enq_dropped got %b exp %b", act_flags, 6'b001001);
            errors++;
        end
        idle_inputs();
    endtask

`ifdef NPU_QUEUE_ERR_EN
    task automatic test_err();
        idle_inputs();
        iFlush = 1'b1;
        tick();
        iFlush      = 1'b0;
        iExNpuDeqOp = 1'b1;
        iStall      = 1'b1;
        tick();
        checks++;
        if (oNpuQueueErr !== 1'b0) begin
            $display("FAIL err_stalled got %b exp 0", oNpuQueueErr);
            errors++;
        end
        iStall = 1'b0;
        tick();
        checks++;
        if (oNpuQueueErr !== 1'b1) begin
            $display("FAIL err_set got %b exp 1", oNpuQueueErr);
            errors++;
        end
        iExNpuDeqOp = 1'b0;
        tick();
        checks++;
        if (oNpuQueueErr !== 1'b1) begin
            $display("FAIL err_sticky got %b exp 1", oNpuQueueErr);
            errors++;
        end
        iFlush = 1'b1;
        tick();
        checks++;
        if (oNpuQueueErr !== 1'b0) begin
            $display("FAIL err_clear got %b exp 0", oNpuQueueErr);
            errors++;
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            iReset_n     = ($urandom_range(0, 99) != 0);
            iFlush       = ($urandom_range(0, 39) == 0);
            iStall       = ($urandom_range(0, 3) == 0);
            iExNpuCfgOp  = $urandom_range(0, 1);
            iExNpuEnqOp  = $urandom_range(0, 1);
            iExNpuDeqOp  = ($urandom_range(0, 2) == 0);
            iExData      = $urandom;
            iNpuCfgReady = ($urandom_range(0, 2) == 0);
            iNpuInReady  = ($urandom_range(0, 2) == 0);
            iNpuOutValid = $urandom_range(0, 1);
            iNpuOutData  = $urandom;
            #1;
            checks++;
            if (act_flags !== exp_flags()) begin
                $display("FAIL rand_flags cyc %0d got %b exp %b", n, act_flags, exp_flags());
                errors++;
            end
            if (cfg_m.size() != 0) begin
                checks++;
                if (oNpuCfgData !== cfg_m[0]) begin
                    $display("FAIL rand_cfg_head cyc %0d got %h exp %h", n, oNpuCfgData, cfg_m[0]);
                    errors++;
                end
            end
            if (in_m.size() != 0) begin
                checks++;
                if (oNpuInData !== in_m[0]) begin
                    $display("FAIL rand_in_head cyc %0d got %h exp %h", n, oNpuInData, in_m[0]);
                    errors++;
                end
            end
            if (out_m.size() != 0) begin
                checks++;
                if (oDeqData !== out_m[0]) begin
                    $display("FAIL rand_deq_head cyc %0d got %h exp %h", n, oDeqData, out_m[0]);
                    errors++;
                end
            end
`ifdef NPU_QUEUE_ERR_EN
            checks++;
            if (oNpuQueueErr !== err_m) begin
                $display("FAIL rand_err cyc %0d got %b exp %b", n, oNpuQueueErr, err_m);
                errors++;
            end
`endif
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        iReset_n = 1'b0;
        test_reset();
        test_input_fill();
        test_output_deq();
        test_simultaneous();
        test_flush();
`ifdef NPU_QUEUE_ERR_EN
        test_err();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
